// File: rtl/mcb_port_master.sv
// mcb_port_master: issues one write or read burst per request on a Spartan-6
// MCB user port. Write data is streamed into the MCB write FIFO before the
// command is issued. Read data is pulled from the MCB read FIFO and
// re-registered towards the user. A watchdog aborts reads that stall.

module mcb_port_master #(
  parameter int RD_TIMEOUT = 1024,
  parameter int BURST_MAX  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        calibration_done,
  input  logic        start,
  input  logic        write,
  input  logic [29:0] address,
  input  logic [6:0]  length,
  output logic        busy,
  output logic        done,
  output logic [3:0]  error,
  input  logic [31:0] usr_wr_data,
  input  logic [3:0]  usr_wr_mask,
  input  logic        usr_wr_valid,
  output logic        usr_wr_ready,
  output logic [31:0] usr_rd_data,
  output logic        usr_rd_valid,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic        wr_full,
  input  logic        wr_empty,
  input  logic        wr_underrun,
  input  logic        wr_error,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  input  logic        rd_overflow,
  input  logic        rd_error
);

  typedef enum logic [2:0] {
    IDLE, WR_FILL, WR_CMD, WR_DRAIN, RD_CMD, RD_DATA, DONE
  } state_t;

  localparam int              TIMER_W     = $clog2(RD_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RD_TIMEOUT - 1);
  localparam logic [7:0]      BURST_MAX_L = 8'(BURST_MAX);

  state_t             state_q, state_d;
  logic [29:0]        addr_q, addr_d;
  logic [6:0]         len_q, len_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         error_q, error_d;
  logic               rejDone_q, rejDone_d;
  logic [31:0]        rdData_q, rdData_d;
  logic               rdValid_q, rdValid_d;
  logic               accept;
  logic               lenBad;

  assign accept = (state_q == IDLE) && start && calibration_done;
  assign lenBad = (length == 7'd0) || ({1'b0, length} > BURST_MAX_L);

  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE) || rejDone_q;
  assign error        = error_q;
  assign usr_rd_data  = rdData_q;
  assign usr_rd_valid = rdValid_q;

  // Next-state and MCB/user handshake outputs; error flags are sticky until the next accepted start.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    rejDone_d     = 1'b0;
    rdData_d      = rdData_q;
    rdValid_d     = 1'b0;
    error_d       = (accept ? 4'b0000 : error_q) |
                    {rd_overflow | rd_error, wr_underrun | wr_error, 2'b00};
    cmd_en        = 1'b0;
    cmd_instr     = 3'b000;
    cmd_bl        = 6'd0;
    cmd_byte_addr = 30'd0;
    wr_en         = 1'b0;
    wr_data       = 32'd0;
    wr_mask       = 4'd0;
    usr_wr_ready  = 1'b0;
    rd_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (lenBad) begin
            error_d[0] = 1'b1;
            rejDone_d  = 1'b1;
          end else begin
            addr_d  = address & ~30'h3;
            len_d   = length;
            cnt_d   = 7'd0;
            state_d = write ? WR_FILL : RD_CMD;
          end
        end
      end
      WR_FILL: begin
        usr_wr_ready = !wr_full;
        wr_en        = usr_wr_valid && !wr_full;
        wr_data      = usr_wr_data;
        wr_mask      = usr_wr_mask;
        if (wr_en) begin
          if (cnt_q + 7'd1 == len_q) begin
            cnt_d   = 7'd0;
            state_d = WR_CMD;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      WR_CMD, RD_CMD: begin
        cmd_instr     = (state_q == WR_CMD) ? 3'b000 : 3'b001;
        cmd_bl        = 6'(len_q - 7'd1);
        cmd_byte_addr = addr_q;
        cmd_en        = !cmd_full;
        if (!cmd_full) begin
          cnt_d   = 7'd0;
          timer_d = '0;
          state_d = (state_q == WR_CMD) ? WR_DRAIN : RD_DATA;
        end
      end
      WR_DRAIN: begin
        if (wr_empty) state_d = DONE;
      end
      RD_DATA: begin
        rd_en = !rd_empty;
        if (!rd_empty) begin
          rdData_d  = rd_data;
          rdValid_d = 1'b1;
          timer_d   = '0;
          if (cnt_q + 7'd1 == len_q) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end else if (timer_q == TIMER_LAST) begin
          error_d[1] = 1'b1;
          state_d    = DONE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= 30'd0;
      len_q     <= 7'd0;
      cnt_q     <= 7'd0;
      timer_q   <= '0;
      error_q   <= 4'd0;
      rejDone_q <= 1'b0;
      rdData_q  <= 32'd0;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      error_q   <= error_d;
      rejDone_q <= rejDone_d;
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

endmodule

// File: tb/tb_mcb_port_master.sv
// tb_mcb_port_master: directed bench with a transaction-level model of the
// MCB FIFOs and the user write stream, plus a per-cycle compare process.

module tb_mcb_port_master;

  localparam int TB_TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst_n, calibration_done, start, write;
  logic [29:0] address;
  logic [6:0]  length;
  logic        busy, done;
  logic [3:0]  error;
  logic [31:0] usr_wr_data;
  logic [3:0]  usr_wr_mask;
  logic        usr_wr_valid, usr_wr_ready;
  logic [31:0] usr_rd_data;
  logic        usr_rd_valid;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full, wr_empty, wr_underrun, wr_error;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty, rd_overflow, rd_error;

  mcb_port_master #(.RD_TIMEOUT(TB_TIMEOUT), .BURST_MAX(64)) dut (
    .clk(clk), .rst_n(rst_n), .calibration_done(calibration_done),
    .start(start), .write(write), .address(address), .length(length),
    .busy(busy), .done(done), .error(error),
    .usr_wr_data(usr_wr_data), .usr_wr_mask(usr_wr_mask),
    .usr_wr_valid(usr_wr_valid), .usr_wr_ready(usr_wr_ready),
    .usr_rd_data(usr_rd_data), .usr_rd_valid(usr_rd_valid),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_full(wr_full), .wr_empty(wr_empty), .wr_underrun(wr_underrun),
    .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cycleNo = 0;
  bit monitorOn = 1'b0;
  int lastWrCycle = 0;
  int lastTakeCycle = 0;
  int emptyCycle = 0;
  int fallCycle = 0;
  bit pendValid = 1'b0;
  logic [31:0] pendData = 32'd0;

  logic [35:0] wrSrc[$];
  logic [31:0] rdFifo[$];
  logic [35:0] expWr[$];
  logic [31:0] expRd[$];
  logic [35:0] wrLog[$];
  logic [38:0] cmdLog[$];
  int          cmdCyc[$];
  logic [31:0] rdLog[$];
  int          doneCyc[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected command word from the request: opcode, length-1, word-aligned address.
  function automatic logic [38:0] expCmd(input bit isWr, input logic [29:0] a, input int len);
    return {(isWr ? 3'b000 : 3'b001), 6'(len - 1), a & ~30'h3};
  endfunction

  task automatic refreshSources();
    rd_empty     = (rdFifo.size() == 0);
    rd_data      = (rdFifo.size() > 0) ? rdFifo[0] : 32'd0;
    usr_wr_valid = (wrSrc.size() > 0);
    usr_wr_data  = (wrSrc.size() > 0) ? wrSrc[0][31:0] : 32'd0;
    usr_wr_mask  = (wrSrc.size() > 0) ? wrSrc[0][35:32] : 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    wrLog.delete(); cmdLog.delete(); cmdCyc.delete(); rdLog.delete(); doneCyc.delete();
    expWr.delete(); expRd.delete();
  endtask

  task automatic applyStimulus(input bit isWr, input logic [29:0] a, input logic [6:0] len);
    start = 1'b1; write = isWr; address = a; length = len;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int k = 0;
    while (doneCyc.size() == 0 && k < budget) begin tick(); k++; end
    checkOutput(name, 64'(doneCyc.size() > 0), 64'd1);
  endtask

  task automatic waitCmd(input string name, input int budget);
    int k = 0;
    while (cmdLog.size() == 0 && k < budget) begin tick(); k++; end
    checkOutput(name, 64'(cmdLog.size() > 0), 64'd1);
  endtask

  // MCB FIFO and user write-stream model: pop whatever the DUT took this cycle.
  initial begin
    bit rdPop, wrPop;
    forever begin
      @(negedge clk);
      rdPop = rst_n && rd_en && !rd_empty;
      wrPop = rst_n && wr_en;
      @(posedge clk);
      #1;
      if (rdPop && rdFifo.size() > 0) void'(rdFifo.pop_front());
      if (wrPop && wrSrc.size() > 0) void'(wrSrc.pop_front());
      refreshSources();
    end
  end

  // Per-cycle compare: guards, write pass-through, read pipeline, event logging.
  initial begin
    forever begin
      @(negedge clk);
      cycleNo++;
      if (monitorOn) begin
        if (cmd_full) checkOutput("cmd_en_guard", 64'(cmd_en), 64'd0);
        if (wr_full)  checkOutput("wr_en_guard", 64'(wr_en), 64'd0);
        if (rd_empty) checkOutput("rd_en_guard", 64'(rd_en), 64'd0);
        if (cmd_en) begin
          cmdLog.push_back({cmd_instr, cmd_bl, cmd_byte_addr});
          cmdCyc.push_back(cycleNo);
        end
        if (wr_en) begin
          checkOutput("wr_passthru", 64'({wr_mask, wr_data}), 64'({usr_wr_mask, usr_wr_data}));
          wrLog.push_back({wr_mask, wr_data});
          lastWrCycle = cycleNo;
        end
        checkOutput("rd_valid", 64'(usr_rd_valid), 64'(pendValid));
        if (pendValid) begin
          checkOutput("rd_data", 64'(usr_rd_data), 64'(pendData));
          rdLog.push_back(usr_rd_data);
        end
        if (done) doneCyc.push_back(cycleNo);
        pendValid = rst_n && rd_en && !rd_empty;
        pendData  = rd_data;
        if (pendValid) lastTakeCycle = cycleNo;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rst_n = 1'b0; calibration_done = 1'b1; start = 1'b0; write = 1'b0;
    address = 30'd0; length = 7'd0; cmd_full = 1'b0; wr_full = 1'b0;
    wr_empty = 1'b1; wr_underrun = 1'b0; wr_error = 1'b0;
    rd_overflow = 1'b0; rd_error = 1'b0;
    refreshSources();

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_error", 64'(error), 64'd0);
    checkOutput("rst_cmd", 64'({cmd_en, cmd_instr, cmd_bl, cmd_byte_addr}), 64'd0);
    checkOutput("rst_enables", 64'({wr_en, rd_en, usr_wr_ready}), 64'd0);
    checkOutput("rst_usr_rd", 64'({usr_rd_valid, usr_rd_data}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; monitorOn = 1'b1;
    tick();

    // 8-word write to 0x100
    clearLogs();
    for (int i = 0; i < 8; i++) begin
      wrSrc.push_back({4'(i + 1), 32'hA5A5_0000 + 32'(i)});
      expWr.push_back({4'(i + 1), 32'hA5A5_0000 + 32'(i)});
    end
    wr_empty = 1'b0;
    tick();
    applyStimulus(1'b1, 30'h100, 7'd8);
    @(negedge clk);
    checkOutput("wr8_busy", 64'(busy), 64'd1);
    checkOutput("wr8_ready", 64'(usr_wr_ready), 64'd1);
    waitCmd("wr8_cmd_seen", 40);
    repeat (3) tick();
    emptyCycle = cycleNo + 1;
    wr_empty = 1'b1;
    waitDone("wr8_done_seen", 20);
    checkOutput("wr8_words", 64'(wrLog.size()), 64'd8);
    for (int i = 0; i < 8; i++) checkOutput("wr8_word", 64'(wrLog[i]), 64'(expWr[i]));
    checkOutput("wr8_cmd_count", 64'(cmdLog.size()), 64'd1);
    checkOutput("wr8_cmd", 64'(cmdLog[0]), 64'(expCmd(1'b1, 30'h100, 8)));
    checkOutput("wr8_cmd_lit", 64'(cmdLog[0]), 64'({3'b000, 6'd7, 30'h100}));
    checkOutput("wr8_cmd_after_data", 64'(cmdCyc[0]), 64'(lastWrCycle + 1));
    checkOutput("wr8_done_after_empty", 64'(doneCyc[0]), 64'(emptyCycle + 1));
    repeat (3) tick();
    checkOutput("wr8_done_once", 64'(doneCyc.size()), 64'd1);

    // 4-word read from unaligned 0x203
    clearLogs();
    for (int i = 0; i < 4; i++) begin
      rdFifo.push_back(32'h1111_1111 * 32'(i + 1));
      expRd.push_back(32'h1111_1111 * 32'(i + 1));
    end
    tick();
    applyStimulus(1'b0, 30'h203, 7'd4);
    waitDone("rd4_done_seen", 40);
    checkOutput("rd4_cmd", 64'(cmdLog[0]), 64'(expCmd(1'b0, 30'h203, 4)));
    checkOutput("rd4_cmd_lit", 64'(cmdLog[0]), 64'({3'b001, 6'd3, 30'h200}));
    checkOutput("rd4_words", 64'(rdLog.size()), 64'd4);
    for (int i = 0; i < 4; i++) checkOutput("rd4_word", 64'(rdLog[i]), 64'(expRd[i]));
    @(negedge clk);
    checkOutput("rd4_error", 64'(error), 64'd0);
    checkOutput("rd4_idle_busy", 64'(busy), 64'd0);
    tick();

    // Write with cmd_full held high
    clearLogs();
    wrSrc.push_back({4'hF, 32'hDEAD_0001});
    wrSrc.push_back({4'h3, 32'hDEAD_0002});
    cmd_full = 1'b1;
    wr_empty = 1'b1;
    tick();
    applyStimulus(1'b1, 30'h300, 7'd2);
    repeat (9) tick();
    fallCycle = cycleNo + 1;
    cmd_full = 1'b0;
    waitCmd("cf_cmd_seen", 5);
    checkOutput("cf_cmd_first_free", 64'(cmdCyc[0]), 64'(fallCycle));
    checkOutput("cf_cmd", 64'(cmdLog[0]), 64'(expCmd(1'b1, 30'h300, 2)));
    waitDone("cf_done_seen", 10);
    checkOutput("cf_cmd_count", 64'(cmdLog.size()), 64'd1);

    // Read timeout: only 2 of 4 words arrive
    clearLogs();
    rdFifo.push_back(32'hBEEF_0001);
    rdFifo.push_back(32'hBEEF_0002);
    tick();
    applyStimulus(1'b0, 30'h40, 7'd4);
    waitDone("to_done_seen", TB_TIMEOUT + 30);
    checkOutput("to_cmd_lit", 64'(cmdLog[0]), 64'({3'b001, 6'd3, 30'h40}));
    checkOutput("to_words", 64'(rdLog.size()), 64'd2);
    checkOutput("to_word1", 64'(rdLog[1]), 64'h0000_0000_BEEF_0002);
    checkOutput("to_latency", 64'(doneCyc[0] - lastTakeCycle), 64'(TB_TIMEOUT + 1));
    @(negedge clk);
    checkOutput("to_error", 64'(error), 64'b0010);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      checkOutput("to_rd_en_low", 64'(rd_en), 64'd0);
    end
    tick();

    // length=0 is rejected
    clearLogs();
    applyStimulus(1'b1, 30'h10, 7'd0);
    @(negedge clk);
    checkOutput("len0_done", 64'(done), 64'd1);
    checkOutput("len0_error", 64'(error), 64'b0001);
    checkOutput("len0_busy", 64'(busy), 64'd0);
    repeat (4) tick();
    checkOutput("len0_done_once", 64'(doneCyc.size()), 64'd1);
    checkOutput("len0_no_cmd", 64'(cmdLog.size()), 64'd0);

    // start ignored while calibration_done=0
    clearLogs();
    calibration_done = 1'b0;
    applyStimulus(1'b0, 30'h10, 7'd4);
    repeat (5) tick();
    @(negedge clk);
    checkOutput("cal0_busy", 64'(busy), 64'd0);
    checkOutput("cal0_error_kept", 64'(error), 64'b0001);
    checkOutput("cal0_no_done", 64'(doneCyc.size()), 64'd0);
    checkOutput("cal0_no_cmd", 64'(cmdLog.size()), 64'd0);
    tick();
    calibration_done = 1'b1;

    // Sticky MCB error flags, cleared by an accepted start
    wr_underrun = 1'b1; tick(); wr_underrun = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("sticky_wr", 64'(error), 64'b0101);
    tick();
    rd_error = 1'b1; tick(); rd_error = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("sticky_rd", 64'(error), 64'b1101);
    tick();

    // length=65 is rejected and clears the older flags
    clearLogs();
    applyStimulus(1'b1, 30'h10, 7'd65);
    @(negedge clk);
    checkOutput("len65_done", 64'(done), 64'd1);
    checkOutput("len65_error", 64'(error), 64'b0001);
    repeat (3) tick();
    checkOutput("len65_no_cmd", 64'(cmdLog.size()), 64'd0);

    // length=64 write is legal
    clearLogs();
    for (int i = 0; i < 64; i++) begin
      wrSrc.push_back({4'hF, 32'h6400_0000 + 32'(i)});
      expWr.push_back({4'hF, 32'h6400_0000 + 32'(i)});
    end
    wr_empty = 1'b1;
    tick();
    applyStimulus(1'b1, 30'h1000, 7'd64);
    waitDone("len64_done_seen", 120);
    checkOutput("len64_words", 64'(wrLog.size()), 64'd64);
    checkOutput("len64_last", 64'(wrLog[63]), 64'(expWr[63]));
    checkOutput("len64_cmd_lit", 64'(cmdLog[0]), 64'({3'b000, 6'd63, 30'h1000}));
    @(negedge clk);
    checkOutput("len64_error", 64'(error), 64'd0);
    tick();

    // Reset in the middle of WR_FILL, then a fresh write
    clearLogs();
    for (int i = 0; i < 8; i++) wrSrc.push_back({4'h1, 32'h5500_0000 + 32'(i)});
    wr_empty = 1'b0;
    tick();
    applyStimulus(1'b1, 30'h80, 7'd8);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("mid_rst_cmd_en", 64'(cmd_en), 64'd0);
    tick();
    rst_n = 1'b1;
    wrSrc.delete();
    clearLogs();
    for (int i = 0; i < 4; i++) begin
      wrSrc.push_back({4'(8 + i), 32'h7700_0000 + 32'(i)});
      expWr.push_back({4'(8 + i), 32'h7700_0000 + 32'(i)});
    end
    wr_empty = 1'b1;
    tick();
    applyStimulus(1'b1, 30'h80, 7'd4);
    waitDone("fresh_done_seen", 30);
    checkOutput("fresh_words", 64'(wrLog.size()), 64'd4);
    for (int i = 0; i < 4; i++) checkOutput("fresh_word", 64'(wrLog[i]), 64'(expWr[i]));
    checkOutput("fresh_cmd_lit", 64'(cmdLog[0]), 64'({3'b000, 6'd3, 30'h80}));
    repeat (3) tick();
    checkOutput("fresh_done_once", 64'(doneCyc.size()), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
